// File: rtl/dct_transpose_buf.sv
// Row-to-column transpose buffer between the row-pass and column-pass DCT cores.
// Two 8x8 banks ping-pong: one fills with rows while the other replays its columns.
module dct_transpose_buf #(
  parameter int DATA_W  = 32,
  parameter int COL_GAP = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                row_valid_i,
  input  logic [DATA_W-1:0]   row_g0_i,
  input  logic [DATA_W-1:0]   row_g1_i,
  input  logic [DATA_W-1:0]   row_g2_i,
  input  logic [DATA_W-1:0]   row_g3_i,
  input  logic [DATA_W-1:0]   row_g4_i,
  input  logic [DATA_W-1:0]   row_g5_i,
  input  logic [DATA_W-1:0]   row_g6_i,
  input  logic [DATA_W-1:0]   row_g7_i,
  output logic [8*DATA_W-1:0] col_data_o,
  output logic                col_start_o,
  output logic [2:0]          col_idx_o,
  output logic                col_last_o,
  output logic                busy_o,
  output logic                overflow_o
);

  localparam int            GW       = (COL_GAP > 1) ? $clog2(COL_GAP) : 1;
  localparam bit            GAP_EN   = (COL_GAP > 0);
  localparam logic [GW-1:0] GAP_LAST = GW'((COL_GAP > 0) ? COL_GAP - 1 : 0);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  logic [DATA_W-1:0]   bank_q [2][8][8];
  logic [DATA_W-1:0]   row_s  [8];

  state_e              state_q, state_d;
  logic [2:0]          col_q, col_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [1:0]          full_q, full_d;
  logic                wb_q, wb_d;
  logic                rb_q, rb_d;
  logic [2:0]          wr_row_q, wr_row_d;
  logic                overflow_q, overflow_d;
  logic                release_s;
  logic                accept_s;

  logic [8*DATA_W-1:0] col_data_q, col_data_d;
  logic                col_start_q, col_start_d;
  logic [2:0]          col_idx_q, col_idx_d;
  logic                col_last_q, col_last_d;
  logic                busy_q, busy_d;

  assign row_s[0] = row_g0_i;
  assign row_s[1] = row_g1_i;
  assign row_s[2] = row_g2_i;
  assign row_s[3] = row_g3_i;
  assign row_s[4] = row_g4_i;
  assign row_s[5] = row_g5_i;
  assign row_s[6] = row_g6_i;
  assign row_s[7] = row_g7_i;

  // Drain FSM next state: walk the columns of the full read bank, then release it.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    gap_d     = gap_q;
    rb_d      = rb_q;
    release_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (full_q[rb_q]) begin
          state_d = S_EMIT;
          col_d   = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EMIT: begin
        if (col_q == 3'd7) begin
          release_s = 1'b1;
          rb_d      = ~rb_q;
          state_d   = S_IDLE;
        end else begin
          col_d = col_q + 3'd1;
          gap_d = {GW{1'b0}};
          if (GAP_EN) begin
            state_d = S_GAP;
          end else begin
            state_d = S_EMIT;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_EMIT;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Write side: a release this cycle frees the bank before the incoming row is judged.
  always_comb begin
    full_d     = full_q;
    wb_d       = wb_q;
    wr_row_d   = wr_row_q;
    overflow_d = overflow_q;
    accept_s   = 1'b0;
    if (release_s) begin
      full_d[rb_q] = 1'b0;
    end else begin
      full_d = full_q;
    end
    if (row_valid_i) begin
      if (!full_d[wb_q]) begin
        accept_s = 1'b1;
        if (wr_row_q == 3'd7) begin
          full_d[wb_q] = 1'b1;
          wb_d         = ~wb_q;
          wr_row_d     = 3'd0;
        end else begin
          wr_row_d = wr_row_q + 3'd1;
        end
      end else begin
        overflow_d = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // Output look-ahead: load the column being entered so the strobe appears with EMIT.
  always_comb begin
    col_data_d  = col_data_q;
    col_start_d = 1'b0;
    col_idx_d   = col_idx_q;
    col_last_d  = 1'b0;
    if (state_d == S_EMIT) begin
      for (int r = 0; r < 8; r++) begin
        col_data_d[(7-r)*DATA_W +: DATA_W] = bank_q[rb_q][r][col_d];
      end
      col_start_d = 1'b1;
      col_idx_d   = col_d;
      col_last_d  = (col_d == 3'd7);
    end else begin
      col_start_d = 1'b0;
    end
    busy_d = full_d[0] | full_d[1] | (state_d != S_IDLE);
  end

  // Control and output registers; clr behaves like reset for everything but the banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_q       <= 3'd0;
      gap_q       <= {GW{1'b0}};
      full_q      <= 2'b00;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      wr_row_q    <= 3'd0;
      overflow_q  <= 1'b0;
      col_data_q  <= {(8*DATA_W){1'b0}};
      col_start_q <= 1'b0;
      col_idx_q   <= 3'd0;
      col_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else if (clr_i) begin
      state_q     <= S_IDLE;
      col_q       <= 3'd0;
      gap_q       <= {GW{1'b0}};
      full_q      <= 2'b00;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      wr_row_q    <= 3'd0;
      overflow_q  <= 1'b0;
      col_data_q  <= {(8*DATA_W){1'b0}};
      col_start_q <= 1'b0;
      col_idx_q   <= 3'd0;
      col_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      gap_q       <= gap_d;
      full_q      <= full_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      wr_row_q    <= wr_row_d;
      overflow_q  <= overflow_d;
      col_data_q  <= col_data_d;
      col_start_q <= col_start_d;
      col_idx_q   <= col_idx_d;
      col_last_q  <= col_last_d;
      busy_q      <= busy_d;
    end
  end

  // Coefficient storage, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int k = 0; k < 8; k++) begin
        bank_q[wb_q][wr_row_q][k] <= row_s[k];
      end
    end
  end

  assign col_data_o  = col_data_q;
  assign col_start_o = col_start_q;
  assign col_idx_o   = col_idx_q;
  assign col_last_o  = col_last_q;
  assign busy_o      = busy_q;
  assign overflow_o  = overflow_q;

endmodule

// File: doc/dct_transpose_buf.md
Name: dct_transpose_buf

Overview:
- Row-to-column transpose buffer for the 2-D 8x8 DCT. It sits directly downstream of the row-pass DCT core.
- Consumes the core's eight 32-bit IEEE-754 coefficients per done pulse and collects eight rows into a block.
- Replays the block column by column as 256-bit vectors with one-cycle start strobes, feeding the column-pass DCT core.
- Ping-pong banks let one block fill while the other drains.

Parameters:
DATA_W, 32, width of one coefficient (float32 bit pattern, passed through untouched)
COL_GAP, 0, idle cycles inserted between consecutive column strobes (0 = back-to-back)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear; same effect as reset, except data arrays
row_valid  input  1  one row accepted per high cycle (driven by row core done)
row_g0..row_g7  input  DATA_W each  row coefficients g0..g7 from row core
col_data  output  8*DATA_W  column vector; row0 element in [255:224] ... row7 element in [31:0] (same packing as core input a1)
col_start  output  1  one-cycle strobe; col_data valid this cycle
col_idx  output  3  column index of current col_data
col_last  output  1  high with col_start for column 7
busy  output  1  high while any bank is full or draining
overflow  output  1  sticky: a row was dropped because the target bank was full

Behaviour:
- Storage: two banks of 8x8 DATA_W. Data arrays are not reset. Per-bank full flag; write bank pointer wb; write row counter wr_row (0..7); read bank pointer rb.
- Reset (rst_n low, async) or clr (sync): all counters, pointers and flags go to 0. col_data=0, col_start=0, col_idx=0, col_last=0, busy=0, overflow=0. Reset mid-drain aborts the drain immediately; the partial block is discarded.
- Write: on row_valid with full[wb]=0, store row_gk into bank[wb][wr_row][k] and increment wr_row. The write that completes row 7 sets full[wb], toggles wb, and zeroes wr_row.
- Row_valid held N cycles = N rows. No backpressure exists.
- Overflow: row_valid while full[wb]=1 and that bank is not being released this cycle:
  - row dropped; wr_row unchanged; overflow<=1.
  - overflow is cleared only by reset or clr.
- Simultaneous release/write: if the drain releases bank X in the same cycle that row_valid targets X, the row is accepted (release takes precedence). overflow does not set.
- Drain FSM states: IDLE, EMIT, GAP.
  - IDLE: if full[rb], go to EMIT with col=0.
  - EMIT: register col_data = {bank[rb][0][col], ..., bank[rb][7][col]}, col_start=1, col_idx=col, col_last=(col==7).
    - If col<7: col++, then go to GAP when COL_GAP>0, else stay in EMIT.
    - If col==7: clear full[rb], toggle rb, go to IDLE.
  - GAP: count COL_GAP cycles, then return to EMIT.
- Outputs are registered. col_start/col_last are low outside EMIT. col_data holds its last value.
- Latency: 8th row_valid in cycle n -> column 0 strobe in cycle n+2. Column k strobe in cycle n+2+k*(COL_GAP+1).
- Between blocks: exactly one IDLE cycle after col_last before the next block's column 0.
- busy = full[0] | full[1] | (state != IDLE).
- Partial block (wr_row<8) is never drained; it waits for its remaining rows.

Test Plan:
- Fill: after reset, 8 rows with row r element c = 32'h000000{r,c}, i.e. 32'h00000000 + (r<<4) + c. -> col_start high in cycles n+2..n+9. Column 0 col_data = {00,10,20,...,70}; column 7 = {07,17,...,77}. col_last only on column 7; busy drops the cycle after col_last.
- Back-to-back: 16 consecutive row_valid cycles (COL_GAP=0). -> first block's col_last, then one idle cycle, then the second block's column 0 with bank-1 data. overflow=0.
- Release/write collision: 24 consecutive rows (COL_GAP=0). -> row 16 lands in the cycle bank 0 is released and is accepted. Three complete blocks drain; overflow=0.
- Overflow: COL_GAP=3, 24 consecutive rows. -> rows arriving while bank 0 is still draining are dropped. overflow=1 and stays 1. The third block drains only once the remaining rows are supplied.
- Async reset mid-drain: assert rst_n low after column 3 strobe. -> outputs 0 immediately. A fresh 8 rows then drains from bank 0, column 0, at n+2.
- clr: pulse clr with overflow=1 and a partial block of 5 rows. -> next cycle overflow=0, busy=0. A new 8-row block drains correctly with none of the 5 stale rows used.
